// File: rtl/sel_rr_n_pkg.sv
// Shared constants and helpers for the N-way registered selector.
package sel_rr_n_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Index width for n items; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((32'sd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sel_rr_n_if.sv
// Producer/consumer bundle for sel_rr_n: channel data, handshakes and the selected output.
interface sel_rr_n_if
  import sel_rr_n_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  localparam int SW = clog2(N);

  logic [N*WIDTH-1:0] iC;
  logic [N-1:0]       iValid;
  logic [N-1:0]       oReady;
  logic [SW-1:0]      iS;
  logic               iMode;
  logic [WIDTH-1:0]   oZ;
  logic [SW-1:0]      oSel;
  logic               oValid;
  logic               iReady;

  modport master (
    output iC, iValid, iS, iMode, iReady,
    input  oReady, oZ, oSel, oValid
  );

  modport slave (
    input  iC, iValid, iS, iMode, iReady,
    output oReady, oZ, oSel, oValid
  );

endinterface

// File: rtl/sel_rr_n_rr_pick.sv
// Round-robin picker: first valid channel after i_ptr, wrapping round to i_ptr itself.
module sel_rr_n_rr_pick
  import sel_rr_n_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [SW-1:0] i_ptr,
  output logic          o_grant,
  output logic [SW-1:0] o_g
);

  logic [N-1:0]  w_rot;
  logic [SW-1:0] w_off;
  logic          w_found;
  int            w_src;
  int            w_dst;

  // Rotate so that bit 0 is the channel right after the last grant.
  always_comb begin
    w_rot = '0;
    w_src = 0;
    for (int j = 0; j < N; j++) begin
      w_src    = (int'(i_ptr) + 1 + j) % N;
      w_rot[j] = i_valid[w_src[SW-1:0]];
    end
  end

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int j = 0; j < N; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found = 1'b1;
        w_off   = SW'(j);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Undo the rotation to get the absolute channel index.
  always_comb begin
    w_dst   = (int'(i_ptr) + 1 + int'(w_off)) % N;
    o_g     = SW'(w_dst);
    o_grant = w_found;
  end

endmodule

// File: rtl/sel_rr_n.sv
// N-way registered selector with valid/ready handshake; direct-index or round-robin grant.
module sel_rr_n
  import sel_rr_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input logic       clk,
  input logic       rst,
  sel_rr_n_if.slave bus
);

  localparam int SW = clog2(N);

  logic [WIDTH-1:0] r_z;
  logic [SW-1:0]    r_sel;
  logic [SW-1:0]    r_ptr;
  logic             r_valid;

  logic             w_load_en;
  logic             w_rr_grant;
  logic [SW-1:0]    w_rr_g;
  logic             w_dir_grant;
  logic             w_grant;
  logic [SW-1:0]    w_g;
  logic [WIDTH-1:0] w_data;
  logic [N-1:0]     w_ready;

  sel_rr_n_rr_pick #(.N(N)) u_rr_pick (
    .i_valid (bus.iValid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_g     (w_rr_g)
  );

  assign w_load_en = !r_valid || bus.iReady;

  // Direct path: out-of-range indices never grant (matters when N is not a power of 2).
  always_comb begin
    w_dir_grant = 1'b0;
    if (int'(bus.iS) < N) begin
      w_dir_grant = bus.iValid[bus.iS];
    end else begin
      w_dir_grant = 1'b0;
    end
  end

  // Mode mux between the direct and round-robin grants.
  always_comb begin
    w_grant = 1'b0;
    w_g     = '0;
    case (bus.iMode)
      MODE_DIRECT: begin
        w_grant = w_dir_grant;
        w_g     = bus.iS;
      end
      MODE_RR: begin
        w_grant = w_rr_grant;
        w_g     = w_rr_g;
      end
      default: begin
        w_grant = 1'b0;
        w_g     = '0;
      end
    endcase
  end

  // Data mux and one-hot accept strobe for the granted channel.
  always_comb begin
    w_data  = '0;
    w_ready = '0;
    for (int k = 0; k < N; k++) begin
      w_data     = w_data | ({WIDTH{w_g == SW'(k)}} & bus.iC[k*WIDTH +: WIDTH]);
      w_ready[k] = w_load_en && w_grant && !rst && (w_g == SW'(k));
    end
  end

  // Output register and round-robin pointer; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z     <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= SW'(N - 1);
    end else if (w_load_en) begin
      if (w_grant) begin
        r_z     <= w_data;
        r_sel   <= w_g;
        r_valid <= 1'b1;
        r_ptr   <= w_g;
      end else begin
        r_valid <= 1'b0;
      end
    end else begin
      r_valid <= r_valid;
    end
  end

  assign bus.oReady = w_ready;
  assign bus.oZ     = r_z;
  assign bus.oSel   = r_sel;
  assign bus.oValid = r_valid;

endmodule
